quad_step_decoder: RTL
======================

Name: quad_step_decoder

Overview:
- Quadrature (A/B) incremental-encoder decoder: the front end that produces the enable/direction stimulus consumed by the 4-bit up/down counter, and tracks the resulting position itself.
- Synchronises and glitch-filters two raw phase inputs and decodes Gray-code transitions into a one-cycle step pulse plus direction.
- Maintains a wrapping WIDTH-bit position count with zero/max flags; flags illegal double-step transitions.

Parameters:
WIDTH, 4, position counter width in bits.
FILTER_CYCLES, 2, consecutive stable cycles required before a synchronised phase value is accepted; legal range 1..15.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; when low, transitions are tracked but step/count are suppressed.
a_in  input  1  raw phase A, asynchronous.
b_in  input  1  raw phase B, asynchronous.
clr_err  input  1  one-cycle pulse clearing the sticky error flag.
step  output  1  one-cycle pulse per accepted legal transition (feeds the counter's trigger/enable).
dir  output  1  direction of last legal step: 0 = up, 1 = down (same encoding as the counter's sel).
count  output  WIDTH  current position.
zero_flag  output  1  high when count == 0.
max_flag  output  1  high when count == 2^WIDTH-1.
err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst high at a rising edge): count=0, step=0, dir=0, err=0, synchroniser flops=0, filter counter=0, init flag set. zero_flag=1, max_flag=0 (combinational from count).
- Synchroniser: two flops per phase; sync AB = {b_sync, a_sync}.
- Filter: candidate register holds sync AB. Filter counter resets to 0 whenever sync AB differs from candidate; otherwise it increments, saturating at FILTER_CYCLES. Accepted state (filt AB) is loaded from candidate when counter reaches FILTER_CYCLES and candidate != filt AB.
- Init: the first acceptance after reset, or the first cycle of stable input if it still equals 00, clears init and adopts the value as reference. No step, count change, or err is generated on it.
- Decode on the cycle filt AB changes (prev -> new):
  - Forward sequence 00->01->11->10->00: up (dir=0).
  - Reverse sequence 00->10->11->01->00: down (dir=1).
  - Both bits changed (00<->11, 01<->10): illegal. Set err; no step; count and dir unchanged.
- Outputs on a legal decode (registered, visible the next cycle):
  - If en=1: step=1 for exactly one cycle; dir updated; count +1 (up) or -1 (down), modulo 2^WIDTH.
  - Wrap: 15 up -> 0; 0 down -> 15 (WIDTH=4).
  - If en=0: step=0 and count held, but dir still updates and prev state is still tracked, so re-enabling never produces a burst.
- Latency (FILTER_CYCLES=N): a raw edge sampled at clock edge k gives a step pulse visible after edge k+N+3. At N=2, a change on a_in appears on step 5 edges later.
- Rate limit: at most one step per N+1 cycles; faster input toggling is filtered out, not queued.
- err: sticky. Cleared by clr_err. If clr_err and a new illegal transition occur in the same cycle, err stays 1 (set wins).
- Reset mid-operation clears everything, including a pending filter count. The next accepted state re-enters init.
- zero_flag and max_flag are pure decodes of count, with no extra latency.

Test Plan:
1. Reset, hold A=B=0 for 10 cycles -> count=0, zero_flag=1, step never pulses, err=0.
2. en=1; drive AB 00->01->11->10->00 four times, each phase held 6 cycles -> 16 step pulses, dir=0; count 0..15 then wraps to 0; max_flag high while count=15.
3. Continue in reverse (00->10->11->01->00), 4 full cycles -> count goes 0 -> 15 -> ... -> 0, dir=1 from the first pulse; zero_flag high at the start and the end.
4. Glitch: from AB=00, pulse a_in high for 1 cycle (FILTER_CYCLES=2) -> no step, count unchanged; hold a_in high for 6 cycles -> exactly one step, 5 cycles after the edge.
5. From AB=00, jump to 11 and hold -> err=1, no step, count unchanged. clr_err pulse -> err=0. Repeat with clr_err in the same cycle as the illegal decode -> err=1.
6. en=0 during 3 up transitions -> no step, count frozen, dir=0. Re-enable, 1 up transition -> exactly 1 step, count +1. Assert rst mid-sequence -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder bus: raw phases and controls in, step/position/status out.
interface quad_step_decoder_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             a_in;
    logic             b_in;
    logic             clr_err;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             zero_flag;
    logic             max_flag;
    logic             err;

    // Driver side (system / testbench)
    modport master (
        output en, a_in, b_in, clr_err,
        input  step, dir, count, zero_flag, max_flag, err
    );

    // Decoder side
    modport slave (
        input  en, a_in, b_in, clr_err,
        output step, dir, count, zero_flag, max_flag, err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B step decoder.
// Raw phases are double-flop synchronised, then debounced: a value must be
// seen unchanged for FILTER_CYCLES+1 consecutive synchronised samples before
// it becomes the accepted state. Each change of the accepted state is decoded
// as a Gray-code step (up/down) or an illegal double-bit jump. Legal steps
// drive a one-cycle step pulse and a wrapping position counter.
module quad_step_decoder #(
    parameter int WIDTH         = 4,
    parameter int FILTER_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave bus
);

    // Filter counter is 4 bits wide, enough for the full 1..15 range.
    localparam logic [3:0]       FC  = 4'(FILTER_CYCLES);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Tracker state: waiting for the first stable reference, or tracking.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // Classification of an accepted-state change.
    typedef enum logic [1:0] {
        MV_NONE = 2'd0,
        MV_UP   = 2'd1,
        MV_DN   = 2'd2,
        MV_BAD  = 2'd3
    } move_e;

    // Synchroniser flops
    logic             a_meta_q, a_sync_q;
    logic             b_meta_q, b_sync_q;
    logic [1:0]       sync_ab;

    // Filter
    logic [1:0]       cand_q, cand_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             stable;

    // Tracker
    state_e           state_q, state_d;
    logic [1:0]       filt_q, filt_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;
    move_e            move;

    // Gray-code transition table, AB = {b, a}.
    // Forward: 00 -> 01 -> 11 -> 10 -> 00. Reverse is the mirror.
    function automatic move_e decode(input logic [1:0] prev, input logic [1:0] nxt);
        move_e m;
        m = MV_NONE;
        case ({prev, nxt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: m = MV_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: m = MV_DN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: m = MV_BAD;
            default:                                m = MV_NONE;
        endcase
        return m;
    endfunction

    // Two-flop synchronisers for the asynchronous phase inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            a_meta_q <= bus.a_in;
            a_sync_q <= a_meta_q;
            b_meta_q <= bus.b_in;
            b_sync_q <= b_meta_q;
        end
    end

    assign sync_ab = {b_sync_q, a_sync_q};

    // Debounce: restart the stability count whenever the synchronised value
    // moves away from the candidate; saturate once it has held long enough.
    always_comb begin
        cand_d = sync_ab;
        fcnt_d = fcnt_q;
        if (sync_ab != cand_q) begin
            fcnt_d = 4'd0;
        end else if (fcnt_q != FC) begin
            fcnt_d = fcnt_q + 4'd1;
        end
    end

    // Filter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= 2'b00;
            fcnt_q <= 4'd0;
        end else begin
            cand_q <= cand_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Candidate has been held for the full filter window.
    assign stable = (fcnt_q == FC);
    assign move   = decode(filt_q, cand_q);

    // Tracker next-state and outputs. Illegal jumps still update the
    // reference so a subsequent legal move decodes from where the shaft is.
    // With en low, dir and the reference keep tracking so that re-enabling
    // never replays missed edges.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        count_d = count_q;
        err_d   = bus.clr_err ? 1'b0 : err_q;

        case (state_q)
            ST_INIT: begin
                if (stable) begin
                    filt_d  = cand_q;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (stable && (cand_q != filt_q)) begin
                    filt_d = cand_q;
                    case (move)
                        MV_UP: begin
                            dir_d = 1'b0;
                            if (bus.en) begin
                                step_d  = 1'b1;
                                count_d = count_q + ONE;
                            end
                        end
                        MV_DN: begin
                            dir_d = 1'b1;
                            if (bus.en) begin
                                step_d  = 1'b1;
                                count_d = count_q - ONE;
                            end
                        end
                        MV_BAD:  err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Tracker state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            filt_q  <= 2'b00;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
    assign bus.zero_flag = (count_q == '0);
    assign bus.max_flag  = (count_q == '1);

endmodule
